mem_stage_hs: RTL and testbench
===============================

# mem_stage_hs

Parametrised memory stage with a variable-latency data-memory handshake, byte/half/word/double load/store sizing and sign/zero extension. It sits between the execute/memory pipeline register and writeback. It owns the M/W pipeline register and stalls upstream while a data-memory transaction is outstanding. Misaligned and illegal-size accesses never reach the bus and are flagged to writeback instead.

## Interface
- XLEN, 64, datapath width; legal values 32 or 64.
- REG_AW, 5, register-index width.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- ValidM  in  1  M-stage instruction valid.
- RegWriteM, MemWriteM, MemReadM, ResultSrcM  in  1 each  control from execute.
- Funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- RD_M  in  REG_AW  destination register.
- PCPlus4M, WriteDataM, ALU_ResultM  in  XLEN each  ALU_ResultM is the byte address.
- StallM  out  1  combinational; upstream must hold M inputs while high.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write enable.
- dmem_addr  out  XLEN  address with the low log2(XLEN/8) bits cleared.
- dmem_be  out  XLEN/8  byte enables.
- dmem_wdata  out  XLEN  store data shifted into the addressed lanes.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  XLEN  read data.
- ValidW, RegWriteW, ResultSrcW, ErrW  out  1 each  writeback control.
- RD_W  out  REG_AW  destination register.
- PCPlus4W, ALU_ResultW, ReadDataW  out  XLEN each  writeback data.

## Operation
- **Memory op:** ValidM & (MemReadM | MemWriteM).
- **Fault:** address not aligned to access size, or size D/WU with XLEN=32. A fault is resolved in one cycle with no bus activity, ErrW=1 and RegWriteW forced to 0.
- **FSM states:** IDLE, WAIT_GNT, WAIT_RD.
  - IDLE, non-faulting memory op: dmem_req=1 in the same cycle.
    - gnt=0 → WAIT_GNT.
    - gnt=1 with read → WAIT_RD.
    - gnt=1 with write → completes, stay IDLE.
  - WAIT_GNT: hold req and all bus outputs stable until gnt. On gnt: read → WAIT_RD; write → completes, go IDLE.
  - WAIT_RD: req=0. On rvalid → completes, go IDLE.
- **rvalid outside WAIT_RD:** ignored.
- **gnt while req=0:** ignored.
- **StallM:** high whenever a memory op is present and does not complete this cycle. Non-memory ops and faults never stall.
- **W register load:**
  - On completion, or for any non-stalled instruction, W loads M fields plus ReadDataW.
  - While StallM=1, W loads a bubble: ValidW=0, RegWriteW=0, ErrW=0, all other W fields 0.
- **Load extraction:** lane = addr[log2(XLEN/8)-1:0]. Shift rdata right by 8×lane, then sign-extend (B/H/W) or zero-extend (BU/HU/WU/D) to XLEN. Non-load ReadDataW=0.
- **Store lanes:** dmem_be = size mask shifted left by lane. dmem_wdata = WriteDataM shifted left by 8×lane.

## Timing
- **Reset** (rst=0 at a rising edge): FSM → IDLE and every W output → 0. An rvalid for a transaction in flight before reset is ignored.
- **Reset-state bus outputs:** combinational from IDLE, so dmem_req/we/be/addr/wdata are 0 whenever ValidM=0.
- **Zero-wait memory** (gnt same cycle, rvalid next cycle):
  - Load: 1 stall cycle; W valid 2 edges after entering M.
  - Store: no stall; W valid 1 edge later.
- **Non-memory instruction / fault:** W valid on the next edge.
- **M inputs** are sampled only in IDLE and on the completion cycle. Changes while stalled are a protocol violation.
- **Back-to-back ops:** a new memory op may assert req in the same cycle its predecessor's W bubble clears, i.e. the cycle after completion.

## Structure
- **Package mem_stage_pkg:** Funct3 size constants, the state enum (IDLE/WAIT_GNT/WAIT_RD), and a function returning the size mask per Funct3.
- **Sub-module load_align:** combinational rdata extraction and extension, parametrised by XLEN. Instantiated once.
- **Top level:** FSM, fault check, store lane shifting and W register.

## Test plan
- **Zero-wait LD:** XLEN=64, addr 0x1000, rdata=0xDEADBEEF_CAFEF00D → one StallM cycle, ReadDataW=0xDEADBEEF_CAFEF00D, ValidW=1.
- **Sign vs zero extension:** LB at 0x1003 with rdata byte3=0x80 → ReadDataW=0xFFFF_FFFF_FFFF_FF80. LBU at the same address → 0x80.
- **SH at 0x1006, WriteDataM=0x1234:** dmem_be=0xC0, dmem_wdata[63:48]=0x1234. gnt delayed 3 cycles → StallM high for 3 cycles, bus outputs stable, W bubbles.
- **Faults:** LW at 0x1002 → no dmem_req, ErrW=1, RegWriteW=0, no stall. LD with XLEN=32 → same result.
- **Reset mid-transaction:** rst=0 in WAIT_RD, then rvalid=1 one cycle after reset release → FSM IDLE, all W outputs 0, rvalid ignored.
- **Back-to-back:** SW, LW, ADD with gnt tied to 1 and rvalid one cycle later → W sequence SW, bubble, LW, ADD with correct RD_W values.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: access-size codes, FSM states and size helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_stage_pkg;

    // Funct3 access size / signedness codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RD  = 2'd2
    } state_e;

    // Byte-enable mask for a lane-0 access; zero marks an illegal size code.
    function automatic logic [7:0] size_mask(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: size_mask = 8'h01;
            F3_H, F3_HU: size_mask = 8'h03;
            F3_W, F3_WU: size_mask = 8'h0F;
            F3_D:        size_mask = 8'hFF;
            default:     size_mask = 8'h00;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [2:0] f3);
        case (f3)
            F3_H, F3_HU: align_mask = 3'b001;
            F3_W, F3_WU: align_mask = 3'b011;
            F3_D:        align_mask = 3'b111;
            default:     align_mask = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_hs_load_align.sv
// Load data extraction: shifts the addressed bytes down to lane 0 and sign/zero extends to XLEN.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
// Ports: rdata_i raw bus word, lane_i byte offset within the word, funct3_i size/sign, data_o result.
module mem_stage_hs_load_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]              rdata_i,
    input  logic [$clog2(XLEN/8)-1:0]    lane_i,
    input  logic [2:0]                   funct3_i,
    output logic [XLEN-1:0]              data_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata_i >> {lane_i, 3'b000};
        case (funct3_i)
            F3_B:    data_o = XLEN'($signed(shifted[7:0]));
            F3_H:    data_o = XLEN'($signed(shifted[15:0]));
            F3_W:    data_o = XLEN'($signed(shifted[31:0]));
            F3_BU:   data_o = XLEN'(shifted[7:0]);
            F3_HU:   data_o = XLEN'(shifted[15:0]);
            F3_WU:   data_o = XLEN'(shifted[31:0]);
            default: data_o = shifted;   // D: full word
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// Memory stage with variable-latency data-memory handshake, load/store sizing and M/W register.
// Latency: non-memory/faulting ops 1 edge; stores 1 edge after gnt; loads 1 edge after rvalid.
// Backpressure: StallM (combinational) holds upstream while a bus transaction has not completed.
// Ports: M-stage controls/data in; dmem_* request/grant/read-return bus; *W writeback register out.
module mem_stage_hs
    import mem_stage_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    // M stage
    input  logic                 ValidM,
    input  logic                 RegWriteM,
    input  logic                 MemWriteM,
    input  logic                 MemReadM,
    input  logic                 ResultSrcM,
    input  logic [2:0]           Funct3M,
    input  logic [REG_AW-1:0]    RD_M,
    input  logic [XLEN-1:0]      PCPlus4M,
    input  logic [XLEN-1:0]      WriteDataM,
    input  logic [XLEN-1:0]      ALU_ResultM,
    output logic                 StallM,
    // data memory bus
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [XLEN-1:0]      dmem_addr,
    output logic [XLEN/8-1:0]    dmem_be,
    output logic [XLEN-1:0]      dmem_wdata,
    input  logic                 dmem_gnt,
    input  logic                 dmem_rvalid,
    input  logic [XLEN-1:0]      dmem_rdata,
    // writeback
    output logic                 ValidW,
    output logic                 RegWriteW,
    output logic                 ResultSrcW,
    output logic                 ErrW,
    output logic [REG_AW-1:0]    RD_W,
    output logic [XLEN-1:0]      PCPlus4W,
    output logic [XLEN-1:0]      ALU_ResultW,
    output logic [XLEN-1:0]      ReadDataW
);

    localparam int BE_W   = XLEN / 8;
    localparam int LANE_W = $clog2(BE_W);

    state_e               state_q;
    logic                 valid_w_q, reg_write_w_q, result_src_w_q, err_w_q;
    logic [REG_AW-1:0]    rd_w_q;
    logic [XLEN-1:0]      pc_plus4_w_q, alu_result_w_q, read_data_w_q;

    logic                 mem_op, size_bad, misaligned, fault, bus_go, complete;
    logic [LANE_W-1:0]    lane;
    logic [7:0]           mask8;
    logic [XLEN-1:0]      load_data, read_data_d;

    assign lane       = ALU_ResultM[LANE_W-1:0];
    assign mask8      = size_mask(Funct3M);
    assign mem_op     = ValidM & (MemReadM | MemWriteM);
    // Doubleword and unsigned-word accesses do not exist on a 32-bit datapath.
    assign size_bad   = (mask8 == 8'h00) ||
                        ((XLEN == 32) && ((Funct3M == F3_D) || (Funct3M == F3_WU)));
    assign misaligned = |(ALU_ResultM[2:0] & align_mask(Funct3M));
    assign fault      = mem_op & (size_bad | misaligned);
    assign bus_go     = mem_op & ~fault;

    // A load is never completed by gnt alone; it needs the rvalid in WAIT_RD.
    always_comb begin
        complete = 1'b0;
        case (state_q)
            IDLE:     complete = bus_go & ~MemReadM & dmem_gnt;
            WAIT_GNT: complete = dmem_gnt & ~MemReadM;
            WAIT_RD:  complete = dmem_rvalid;
            default:  complete = 1'b0;
        endcase
    end

    assign StallM = ((state_q != IDLE) | bus_go) & ~complete;

    // Bus fields are driven straight from the held M inputs and zeroed whenever req is low,
    // so they stay stable through WAIT_GNT because upstream is stalled.
    assign dmem_req   = ((state_q == IDLE) & bus_go) | (state_q == WAIT_GNT);
    assign dmem_we    = dmem_req & ~MemReadM;
    assign dmem_addr  = dmem_req ? {ALU_ResultM[XLEN-1:LANE_W], {LANE_W{1'b0}}} : '0;
    assign dmem_be    = dmem_req ? (BE_W'(mask8) << lane) : '0;
    assign dmem_wdata = dmem_req ? (WriteDataM << {lane, 3'b000}) : '0;

    mem_stage_hs_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i  (dmem_rdata),
        .lane_i   (lane),
        .funct3_i (Funct3M),
        .data_o   (load_data)
    );

    assign read_data_d = (ValidM & MemReadM & complete) ? load_data : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_go) begin
                        if (!dmem_gnt)     state_q <= WAIT_GNT;
                        else if (MemReadM) state_q <= WAIT_RD;
                    end
                end
                WAIT_GNT: if (dmem_gnt)    state_q <= MemReadM ? WAIT_RD : IDLE;
                WAIT_RD:  if (dmem_rvalid) state_q <= IDLE;
                default:                   state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || StallM) begin
            // Reset and stalled cycles both leave an all-zero bubble in W.
            valid_w_q      <= 1'b0;
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= 1'b0;
            err_w_q        <= 1'b0;
            rd_w_q         <= '0;
            pc_plus4_w_q   <= '0;
            alu_result_w_q <= '0;
            read_data_w_q  <= '0;
        end else begin
            valid_w_q      <= ValidM;
            reg_write_w_q  <= RegWriteM & ~fault;
            result_src_w_q <= ResultSrcM;
            err_w_q        <= fault;
            rd_w_q         <= RD_M;
            pc_plus4_w_q   <= PCPlus4M;
            alu_result_w_q <= ALU_ResultM;
            read_data_w_q  <= read_data_d;
        end
    end

    assign ValidW      = valid_w_q;
    assign RegWriteW   = reg_write_w_q;
    assign ResultSrcW  = result_src_w_q;
    assign ErrW        = err_w_q;
    assign RD_W        = rd_w_q;
    assign PCPlus4W    = pc_plus4_w_q;
    assign ALU_ResultW = alu_result_w_q;
    assign ReadDataW   = read_data_w_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: scoreboard of expected W records, bus/stall checks per cycle.
// Latency: n/a.
// Backpressure: bench drives dmem_gnt/dmem_rvalid with programmable delays.
module tb_mem_stage_hs;
    import mem_stage_pkg::*;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic        err;
        logic        rs;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] rdat;
    } w_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ValidM, RegWriteM, MemWriteM, MemReadM, ResultSrcM, valid32;
    logic [2:0]  Funct3M;
    logic [4:0]  RD_M;
    logic [63:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic        StallM, dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [63:0] dmem_rdata;
    logic        ValidW, RegWriteW, ResultSrcW, ErrW;
    logic [4:0]  RD_W;
    logic [63:0] PCPlus4W, ALU_ResultW, ReadDataW;

    logic        stall_32, req_32, we_32, vw_32, rw_32, rs_32, err_32;
    logic [31:0] addr_32, wdata_32, pc_32, alu_32, rdw_32;
    logic [3:0]  be_32;
    logic [4:0]  rd_32;

    mem_stage_hs #(.XLEN(64), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .StallM(StallM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .ValidW(ValidW), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .ErrW(ErrW), .RD_W(RD_W), .PCPlus4W(PCPlus4W),
        .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW)
    );

    mem_stage_hs #(.XLEN(32), .REG_AW(5)) dut32 (
        .clk(clk), .rst(rst),
        .ValidM(valid32), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M[31:0]),
        .WriteDataM(WriteDataM[31:0]), .ALU_ResultM(ALU_ResultM[31:0]), .StallM(stall_32),
        .dmem_req(req_32), .dmem_we(we_32), .dmem_addr(addr_32), .dmem_be(be_32),
        .dmem_wdata(wdata_32), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata[31:0]), .ValidW(vw_32), .RegWriteW(rw_32),
        .ResultSrcW(rs_32), .ErrW(err_32), .RD_W(rd_32), .PCPlus4W(pc_32),
        .ALU_ResultW(alu_32), .ReadDataW(rdw_32)
    );

    w_t obs_w;
    assign obs_w = {ValidW, RegWriteW, ErrW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW};

    int checks = 0;
    int errors = 0;
    w_t exp_q[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input logic rw, input logic err, input logic rs, input logic [4:0] rd,
                          input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] rdat);
        w_t e;
        e = '{v: 1'b1, rw: rw, err: err, rs: rs, rd: rd, pc: pc, alu: alu, rdat: rdat};
        exp_q.push_back(e);
    endtask

    task automatic expect_w(input string tag);
        w_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty, observed=%0h", tag, obs_w);
        end else begin
            e = exp_q.pop_front();
            check(tag, 256'(obs_w), 256'(e));
        end
    endtask

    task automatic drive_m(input logic v, input logic rw, input logic mw, input logic mr,
                           input logic rs, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [63:0] pc, input logic [63:0] wd, input logic [63:0] alu);
        ValidM = v; RegWriteM = rw; MemWriteM = mw; MemReadM = mr; ResultSrcM = rs;
        Funct3M = f3; RD_M = rd; PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
    endtask

    task automatic idle_m();
        drive_m(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 64'd0, 64'd0, 64'd0);
    endtask

    // One memory transaction; starts and ends 1 time unit after a rising edge.
    task automatic run_mem(input string tag, input logic rd_op, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wdat, input logic [4:0] rd,
                           input int gnt_dly, input logic [63:0] rdata_in,
                           input logic [63:0] exp_rdat, input int exp_stall,
                           input logic [7:0] exp_be, input logic [63:0] exp_wdata);
        int          cdone;
        int          stalls;
        logic [63:0] pc;
        pc     = 64'h4000 + {59'd0, rd};
        cdone  = rd_op ? gnt_dly + 1 : gnt_dly;
        stalls = 0;
        push_w(rd_op, 1'b0, rd_op, rd, pc, addr, rd_op ? exp_rdat : 64'd0);
        drive_m(1'b1, rd_op, !rd_op, rd_op, rd_op, f3, rd, pc, wdat, addr);
        for (int c = 0; c <= cdone; c++) begin
            dmem_gnt    = (c == gnt_dly);
            dmem_rvalid = rd_op && (c == cdone);
            dmem_rdata  = (rd_op && c == cdone) ? rdata_in : {$urandom, $urandom};
            #1;
            if (StallM) stalls++;
            if (c <= gnt_dly)
                check({tag, "_bus"}, {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata},
                      {1'b1, !rd_op, addr & ~64'h7, exp_be, exp_wdata});
            else
                check({tag, "_req_low"}, 256'(dmem_req), 256'(0));
            if (c > 0) check({tag, "_bubble"}, 256'(obs_w), 256'(0));
            tick();
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        check({tag, "_stall_cycles"}, 256'(stalls), 256'(exp_stall));
        expect_w({tag, "_w"});
    endtask

    // Single-cycle instruction: non-memory op or faulting access.
    task automatic run_single(input string tag, input logic mw, input logic mr, input logic rw,
                              input logic [2:0] f3, input logic [4:0] rd, input logic [63:0] alu,
                              input logic exp_err);
        logic [63:0] pc;
        pc = 64'h8000 + {59'd0, rd};
        push_w(exp_err ? 1'b0 : rw, exp_err, mr, rd, pc, alu, 64'd0);
        drive_m(1'b1, rw, mw, mr, mr, f3, rd, pc, 64'hFFFF, alu);
        dmem_gnt = 1'b1;   // a grant with no request must be harmless
        #1;
        check({tag, "_nobus"}, {StallM, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata}, 256'(0));
        tick();
        dmem_gnt = 1'b0;
        expect_w({tag, "_w"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; valid32 = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 64'd0;
        idle_m();
        tick(); tick();
        check("reset_w", 256'(obs_w), 256'(0));
        check("reset_bus", {StallM, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata}, 256'(0));
        rst = 1'b1;
        tick();

        // zero-wait loads with lane extraction and extension
        run_mem("ld",  1'b1, F3_D,  64'h1000, 64'd0, 5'd1, 0, 64'hDEADBEEF_CAFEF00D,
                64'hDEADBEEF_CAFEF00D, 1, 8'hFF, 64'd0);
        run_mem("lb",  1'b1, F3_B,  64'h1003, 64'd0, 5'd2, 0, 64'h0000_0000_8000_0000,
                64'hFFFF_FFFF_FFFF_FF80, 1, 8'h08, 64'd0);
        run_mem("lbu", 1'b1, F3_BU, 64'h1003, 64'd0, 5'd3, 0, 64'h0000_0000_8000_0000,
                64'h0000_0000_0000_0080, 1, 8'h08, 64'd0);
        run_mem("lw",  1'b1, F3_W,  64'h1004, 64'd0, 5'd4, 0, 64'h8000_0001_0000_0000,
                64'hFFFF_FFFF_8000_0001, 1, 8'hF0, 64'd0);
        run_mem("lhu", 1'b1, F3_HU, 64'h1002, 64'd0, 5'd5, 0, 64'h0000_0000_F00D_0000,
                64'h0000_0000_0000_F00D, 1, 8'h0C, 64'd0);
        // delayed grants
        run_mem("sh_gnt3", 1'b0, F3_H, 64'h1006, 64'h1234, 5'd6, 3, 64'd0,
                64'd0, 3, 8'hC0, 64'h1234_0000_0000_0000);
        run_mem("ld_gnt2", 1'b1, F3_D, 64'h2008, 64'd0, 5'd7, 2, 64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_CDEF, 3, 8'hFF, 64'd0);

        // faults and a plain ALU op
        run_single("lw_misalign", 1'b0, 1'b1, 1'b1, F3_W,   5'd8,  64'h1002, 1'b1);
        run_single("sd_misalign", 1'b1, 1'b0, 1'b0, F3_D,   5'd9,  64'h1004, 1'b1);
        run_single("lh_misalign", 1'b0, 1'b1, 1'b1, F3_H,   5'd10, 64'h1001, 1'b1);
        run_single("illegal_f3",  1'b0, 1'b1, 1'b1, 3'b111, 5'd11, 64'h1000, 1'b1);
        run_single("add",         1'b0, 1'b0, 1'b1, F3_B,   5'd12, 64'h55,   1'b0);

        // back-to-back SW, LW, ADD with grant always available
        run_mem("b2b_sw", 1'b0, F3_W, 64'h1008, 64'hAABBCCDD, 5'd13, 0, 64'd0,
                64'd0, 0, 8'h0F, 64'h0000_0000_AABB_CCDD);
        run_mem("b2b_lw", 1'b1, F3_W, 64'h100C, 64'd0, 5'd14, 0, 64'h1122_3344_0000_0000,
                64'h0000_0000_1122_3344, 1, 8'hF0, 64'd0);
        run_single("b2b_add", 1'b0, 1'b0, 1'b1, F3_B, 5'd15, 64'h77, 1'b0);

        // LD on a 32-bit datapath is a fault
        idle_m();
        tick();
        drive_m(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, F3_D, 5'd16, 64'h9010, 64'd0, 64'h1000);
        valid32 = 1'b1;
        #1;
        check("x32_ld_nobus", {stall_32, req_32, we_32, addr_32, be_32, wdata_32}, 256'(0));
        tick();
        check("x32_ld_w", {vw_32, rw_32, err_32, rs_32, rd_32, pc_32, alu_32, rdw_32},
              {1'b1, 1'b0, 1'b1, 1'b1, 5'd16, 32'h9010, 32'h1000, 32'd0});
        valid32 = 1'b0;
        idle_m();
        tick();

        // reset while waiting for read data; a late rvalid must be ignored
        drive_m(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, F3_D, 5'd17, 64'h4011, 64'd0, 64'h2000);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #1;
        check("rst_pre_stall", 256'(StallM), 256'(1));
        rst = 1'b0;
        idle_m();
        tick();
        rst = 1'b1;
        #1;
        check("rst_w_zero", 256'(obs_w), 256'(0));
        check("rst_bus_idle", {StallM, dmem_req}, 256'(0));
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'hFEED_FACE_0BAD_BEEF;
        #1;
        check("rst_rvalid_nostall", 256'(StallM), 256'(0));
        tick();
        dmem_rvalid = 1'b0;
        check("rst_rvalid_ignored_w", 256'(obs_w), 256'(0));
        tick();
        check("rst_final_w", 256'(obs_w), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
